// File: rtl/grayscale_pipe_if.sv
// AXI-Stream style beat bundle for the grayscale pipe; W is the tdata width.
interface grayscale_pipe_if #(
    parameter int W = 24
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/grayscale_pipe.sv
// Multi-pixel RGB -> luma converter, two register stages, frame-aligned coefficient update.
// Define GRAYSCALE_ROUND_EN to round half up before the shift; otherwise the sum is truncated.
module grayscale_pipe #(
    parameter int DATA_WIDTH      = 8,
    parameter int PIXELS_PER_BEAT = 1,
    parameter int COEF_WIDTH      = 9,
    parameter int COEF_FRAC       = 8,
    parameter int COEF_R_INIT     = 77,
    parameter int COEF_G_INIT     = 150,
    parameter int COEF_B_INIT     = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    grayscale_pipe_if.slave       s_axis,
    grayscale_pipe_if.master      m_axis,
    input  logic [COEF_WIDTH-1:0] cfg_coef_r,
    input  logic [COEF_WIDTH-1:0] cfg_coef_g,
    input  logic [COEF_WIDTH-1:0] cfg_coef_b,
    input  logic                  cfg_load,
    output logic                  cfg_pending
);
    localparam int DW = DATA_WIDTH;
    localparam int NL = PIXELS_PER_BEAT;
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int SW = PW + 2;

`ifdef GRAYSCALE_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    typedef struct packed {
        logic [COEF_WIDTH-1:0] r;
        logic [COEF_WIDTH-1:0] g;
        logic [COEF_WIDTH-1:0] b;
    } coef_t;

    localparam coef_t COEF_INIT = '{r: COEF_WIDTH'(COEF_R_INIT),
                                    g: COEF_WIDTH'(COEF_G_INIT),
                                    b: COEF_WIDTH'(COEF_B_INIT)};

    coef_t act_q, act_d, shd_q, shd_d, use_coef;
    logic  pend_q, pend_d;
    logic  en, acc, apply;
    logic [1:0] vld_q, user_q, last_q;
    logic [NL-1:0][DW-1:0] y;

    assign en            = !vld_q[1] || m_axis.tready;
    assign s_axis.tready = en && !rst;
    assign acc           = s_axis.tvalid && s_axis.tready;
    assign apply         = acc && s_axis.tuser && pend_q;

    // The SOF beat that applies the shadow is itself computed with it; a load
    // landing in that same cycle only refills the shadow for the next frame.
    always_comb begin
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        use_coef = act_q;
        if (apply) begin
            use_coef = shd_q;
            act_d    = shd_q;
            pend_d   = 1'b0;
        end
        if (cfg_load) begin
            shd_d  = '{r: cfg_coef_r, g: cfg_coef_g, b: cfg_coef_b};
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= COEF_INIT;
            shd_q  <= COEF_INIT;
            pend_q <= 1'b0;
            vld_q  <= '0;
            user_q <= '0;
            last_q <= '0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            if (en) begin
                vld_q  <= {vld_q[0], acc};
                user_q <= {user_q[0], s_axis.tuser};
                last_q <= {last_q[0], s_axis.tlast};
            end
        end
    end

    for (genvar p = 0; p < NL; p++) begin : g_lane
        logic [PW-1:0] pr_d, pg_d, pb_d, pr_q, pg_q, pb_q;
        logic [SW-1:0] sum, sh;
        logic [DW-1:0] y_d, y_q;

        assign pr_d = PW'(s_axis.tdata[p*3*DW + 2*DW +: DW]) * PW'(use_coef.r);
        assign pg_d = PW'(s_axis.tdata[p*3*DW +   DW +: DW]) * PW'(use_coef.g);
        assign pb_d = PW'(s_axis.tdata[p*3*DW        +: DW]) * PW'(use_coef.b);

        // Saturation follows the shift so only the integer part is clamped.
        always_comb begin
            sum = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + RND;
            sh  = sum >> COEF_FRAC;
            y_d = (|(sh >> DW)) ? {DW{1'b1}} : sh[DW-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pr_q <= '0;
                pg_q <= '0;
                pb_q <= '0;
                y_q  <= '0;
            end else if (en) begin
                pr_q <= pr_d;
                pg_q <= pg_d;
                pb_q <= pb_d;
                y_q  <= y_d;
            end
        end

        assign y[p] = y_q;
    end

    assign m_axis.tdata  = y;
    assign m_axis.tvalid = vld_q[1];
    assign m_axis.tuser  = user_q[1];
    assign m_axis.tlast  = last_q[1];
    assign cfg_pending   = pend_q;
endmodule

// File: tb/tb_grayscale_pipe.sv
// Scoreboard bench for grayscale_pipe with two pixels per beat.
module tb_grayscale_pipe;
    localparam int DW = 8;
    localparam int NP = 2;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grayscale_pipe_if #(.W(3*DW*NP)) s_if ();
    grayscale_pipe_if #(.W(DW*NP))   m_if ();

    logic [CW-1:0] cfg_r, cfg_g, cfg_b;
    logic          cfg_load, cfg_pending;

    grayscale_pipe #(.PIXELS_PER_BEAT(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .cfg_coef_r (cfg_r),
        .cfg_coef_g (cfg_g),
        .cfg_coef_b (cfg_b),
        .cfg_load   (cfg_load),
        .cfg_pending(cfg_pending)
    );

    typedef struct {
        logic [DW*NP-1:0] data;
        logic             user;
        logic             last;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_err = 0, cyc = 0, mode = 0, rdy_cnt = 0;
    int act_r = 77, act_g = 150, act_b = 29;
    int shd_r = 77, shd_g = 150, shd_b = 29;
    bit pend = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] luma(input int r, g, b, cr, cg, cb);
        int s;
        s = r*cr + g*cg + b*cb;
`ifdef GRAYSCALE_ROUND_EN
        s = s + 128;
`endif
        s = s >> 8;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [23:0] px(input int r, g, b);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [47:0] rnd();
        return {16'($urandom), $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (rdy_cnt % 3 == 0);
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Output side: pops on handshake, checks hold-while-stalled and s_tready.
    initial begin
        bit prev_stall = 0;
        logic [DW*NP-1:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 0;
            else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(m_if.tvalid), 64'(1));
                    chk("hold_data", 64'(m_if.tdata), 64'(prev_d));
                end
                chk("s_tready", 64'(s_if.tready), 64'(!(m_if.tvalid && !m_if.tready)));
                if (m_if.tvalid && m_if.tready) begin
                    if (sb.size() == 0) chk("spurious_beat", 64'(1), 64'(0));
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("m_tdata", 64'(m_if.tdata), 64'(e.data));
                        chk("m_tuser", 64'(m_if.tuser), 64'(e.user));
                        chk("m_tlast", 64'(m_if.tlast), 64'(e.last));
                        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(2));
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_d     = m_if.tdata;
            end
        end
    end

    task automatic model_step(input bit acc, input bit user, input bit load,
                              input int nr, input int ng, input int nb,
                              output int cr, output int cg, output int cb);
        bit apply;
        apply = acc && user && pend;
        cr = act_r; cg = act_g; cb = act_b;
        if (apply) begin
            cr = shd_r; cg = shd_g; cb = shd_b;
            act_r = shd_r; act_g = shd_g; act_b = shd_b;
        end
        if (load) begin
            shd_r = nr; shd_g = ng; shd_b = nb;
            pend = 1;
        end else if (apply) pend = 0;
    endtask

    task automatic send(input logic [47:0] d, input bit user, input bit last,
                        input bit load, input int nr, input int ng, input int nb);
        int cr, cg, cb, guard;
        bit done;
        exp_t e;
        done = 0; guard = 0;
        s_if.tdata = d; s_if.tuser = user; s_if.tlast = last; s_if.tvalid = 1'b1;
        cfg_load = load; cfg_r = CW'(nr); cfg_g = CW'(ng); cfg_b = CW'(nb);
        while (!done) begin
            @(negedge clk);
            done = s_if.tready;
            model_step(done, user, cfg_load, nr, ng, nb, cr, cg, cb);
            if (done) begin
                for (int p = 0; p < NP; p++)
                    e.data[p*8 +: 8] = luma(int'(d[p*24+16 +: 8]), int'(d[p*24+8 +: 8]),
                                            int'(d[p*24 +: 8]), cr, cg, cb);
                e.user = user; e.last = last; e.cyc = cyc; e.lat = (mode == 0);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            cfg_load = 1'b0;
            guard++;
            if (!done && guard > 200) begin
                chk("accept_timeout", 64'(0), 64'(1));
                done = 1;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle_load(input int nr, input int ng, input int nb);
        int cr, cg, cb;
        s_if.tvalid = 1'b0;
        cfg_load = 1'b1; cfg_r = CW'(nr); cfg_g = CW'(ng); cfg_b = CW'(nb);
        @(negedge clk);
        model_step(0, 0, 1, nr, ng, nb, cr, cg, cb);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        #1;
    endtask

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        cfg_load = 1'b0; cfg_r = '0; cfg_g = '0; cfg_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_if.tready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_if.tdata), 64'(0));
        chk("rst_m_tuser", 64'(m_if.tuser), 64'(0));
        chk("rst_m_tlast", 64'(m_if.tlast), 64'(0));
        chk("rst_cfg_pending", 64'(cfg_pending), 64'(0));
        chk("rst_rel_s_tready", 64'(s_if.tready), 64'(1));
        @(posedge clk);
        #1;

        // Reference pixel and white/black split beat
        send({px(24, 99, 174), px(24, 99, 174)}, 1, 0, 0, 0, 0, 0);
        send({px(255, 255, 255), px(0, 0, 0)}, 0, 1, 0, 0, 0, 0);
        drain();

        // 16-beat stream under 1,0,0 backpressure, tlast on beat 7
        mode = 1;
        for (int i = 0; i < 16; i++) send(rnd(), i == 0, i == 7, 0, 0, 0, 0);
        drain();
        mode = 0;

        // Mid-frame load, applied at next SOF (white saturates)
        send(rnd(), 1, 0, 0, 0, 0, 0);
        send(rnd(), 0, 0, 0, 0, 0, 0);
        send(rnd(), 0, 0, 1, 255, 255, 255);
        send(rnd(), 0, 0, 0, 0, 0, 0);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        chk("pend_mid_frame", 64'(cfg_pending), 64'(1));
        send({px(255, 255, 255), px(0, 0, 0)}, 1, 0, 0, 0, 0, 0);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        drain();
        chk("pend_applied", 64'(cfg_pending), 64'(0));

        // Load coinciding with SOF accept
        idle_load(100, 100, 56);
        send(rnd(), 1, 0, 1, 50, 200, 6);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        chk("pend_same_cycle", 64'(cfg_pending), 64'(1));
        send(rnd(), 1, 0, 0, 0, 0, 0);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        drain();
        chk("pend_after_sof", 64'(cfg_pending), 64'(0));

        // Repeated loads: last one wins
        idle_load(10, 20, 30);
        idle_load(60, 120, 76);
        send(rnd(), 1, 0, 0, 0, 0, 0);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        drain();

        // Reset with beats in flight and a pending load
        idle_load(255, 255, 255);
        mode = 2;
        @(posedge clk);
        #1;
        send(rnd(), 0, 0, 0, 0, 0, 0);
        send(rnd(), 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        sb.delete();
        act_r = 77; act_g = 150; act_b = 29;
        shd_r = 77; shd_g = 150; shd_b = 29;
        pend = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("post_rst_pending", 64'(cfg_pending), 64'(0));
        mode = 0;
        @(posedge clk);
        #1;
        send({px(24, 99, 174), px(255, 255, 255)}, 1, 0, 0, 0, 0, 0);
        send(rnd(), 0, 1, 0, 0, 0, 0);
        drain();
        chk("final_queue_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/grayscale_pipe.md
Name: grayscale_pipe

Overview:
- Parametrised successor to the single-pixel grayscale converter in the video-preprocessing chain.
- Converts PIXELS_PER_BEAT packed RGB pixels per AXI-Stream beat to luma Y = (R*cr + G*cg + B*cb) >> COEF_FRAC.
- Fully pipelined at one beat per cycle with backpressure.
- Coefficients are runtime-programmable, with a frame-aligned update; start-of-frame (tuser) and end-of-line (tlast) pass through aligned with data.

Parameters:
DATA_WIDTH, 8, bits per colour component and per output luma sample
PIXELS_PER_BEAT, 1, pixels per beat (1, 2, 4)
COEF_WIDTH, 9, unsigned coefficient width
COEF_FRAC, 8, right shift applied to the weighted sum
COEF_R_INIT, 77, red coefficient after reset
COEF_G_INIT, 150, green coefficient after reset
COEF_B_INIT, 29, blue coefficient after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_tdata  in  3*DATA_WIDTH*PIXELS_PER_BEAT  pixel p at bits [p*3*DW +: 3*DW], layout {R,G,B}, R at MSB
s_tvalid  in  1  input beat valid
s_tready  out  1  input beat accepted when s_tvalid && s_tready
s_tuser  in  1  start of frame, first beat of frame
s_tlast  in  1  end of line
m_tdata  out  DATA_WIDTH*PIXELS_PER_BEAT  luma p at bits [p*DW +: DW]
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream ready
m_tuser  out  1  delayed s_tuser
m_tlast  out  1  delayed s_tlast
cfg_coef_r  in  COEF_WIDTH  new red coefficient
cfg_coef_g  in  COEF_WIDTH  new green coefficient
cfg_coef_b  in  COEF_WIDTH  new blue coefficient
cfg_load  in  1  one-cycle pulse: capture cfg_coef_* into the shadow registers
cfg_pending  out  1  shadow holds values not yet applied

Behaviour:
- Reset (clk and rst are decided: one clock, synchronous active-high reset named rst):
  - m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, cfg_pending=0.
  - Both active and shadow coefficients load the *_INIT values.
  - All pipeline stage valids clear; any in-flight beats are discarded.
  - s_tready=1 from the first cycle after reset deasserts.
  - While rst=1, s_tready=0.
- Pipeline: two register stages.
  - S1 registers the per-pixel products: 3*PIXELS_PER_BEAT multipliers, each DATA_WIDTH+COEF_WIDTH bits.
  - S2 registers the sum (DATA_WIDTH+COEF_WIDTH+2 bits), shifted right by COEF_FRAC and saturated to 2^DATA_WIDTH-1. S2 drives the m_* outputs.
  - tuser and tlast ride alongside each stage.
- Advance enable: en = !m_tvalid || m_tready. When en=1, all stages shift. s_tready = en && !rst. There is no combinational path from s_tvalid to m_tvalid.
- Latency: 2 cycles from the accept edge to m_tvalid=1 when there is no backpressure. Throughput is 1 beat per cycle.
- Backpressure: while m_tvalid=1 && m_tready=0, m_tdata, m_tuser and m_tlast are held stable and the pipeline freezes. Held data is never overwritten or dropped.
- Bubbles: a stage captures a bubble when en=1 and the upstream valid is 0. Bubbles collapse naturally.
- Coefficient update:
  - cfg_load=1 copies cfg_coef_* into the shadow and sets cfg_pending=1.
  - On acceptance of a beat with s_tuser=1 while cfg_pending=1, the shadow copies to the active set and cfg_pending clears. That SOF beat is computed with the new coefficients.
  - If cfg_load and an SOF accept occur in the same cycle, the SOF beat uses the previous shadow contents. The newly loaded values go to the shadow and cfg_pending stays 1 until the next SOF.
  - Repeated cfg_load before an SOF: the last load wins.
- Arithmetic: all unsigned. Saturation is applied after the shift. With default coefficients (sum 256) saturation never triggers.

Optional Feature:
- Macro GRAYSCALE_ROUND_EN.
- Defined: 2^(COEF_FRAC-1) is added to the sum before the shift (round half up), then saturated. Latency is unchanged.
- Undefined: truncation, i.e. a plain shift. This matches the existing grayscale block bit-exactly for the default coefficients.

Test Plan:
- Defaults, PIXELS_PER_BEAT=1, RGB (24,99,174) with m_tready=1:
  - Sum 21744, output Y=84 two cycles after accept.
  - With GRAYSCALE_ROUND_EN, Y=85.
- PIXELS_PER_BEAT=2, beat {pixel1=(255,255,255), pixel0=(0,0,0)} -> m_tdata={255,0}.
- Stream of 16 beats with m_tready toggling 1,0,0,1,...:
  - Outputs are in order and none lost or duplicated.
  - m_tdata is stable while stalled.
  - s_tready=0 exactly when m_tvalid=1 && m_tready=0.
  - tlast on beat 7 appears on output beat 7.
- cfg_load with (255,255,255) mid-frame:
  - Remaining beats of the frame still use 77/150/29; cfg_pending=1.
  - Next SOF beat with white input gives sum 195075, >>8 = 762, saturated to 255. cfg_pending=0 afterwards.
- cfg_load asserted in the same cycle as an SOF accept:
  - That frame uses the old coefficients.
  - The following SOF applies the new coefficients.
- rst=1 asserted with 2 beats in flight and m_tready=0:
  - Next cycle m_tvalid=0 and cfg_pending=0; coefficients return to 77/150/29.
  - The first beat after reset produces the correct Y at latency 2.
